// File: rtl/bus_interface_unit.sv
// Bus interface unit: sequences one read or write at a time onto the external
// 8-bit memory bus, holds the cycle open through wait states, captures read
// data and aborts accesses that exceed TIMEOUT cycles without mem_ready.
module bus_interface_unit #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        inc,
    input  logic [15:0] addr_in,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [15:0] mem_addr,
    inout  wire  [7:0]  mem_data,
    output logic        mem_rw,
    output logic        mem_valid,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [8:0]  cnt_inc;
    logic        drive_bus;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept in IDLE, wait for ready or timeout in ACCESS
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_inc = {1'b0, cnt_q} + 9'd1;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    wdata_d = wdata;
                    addr_d  = inc ? addr_q + 16'd1 : addr_in;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // ready wins over timeout on the same cycle
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_data;
                    end
                    done_d  = 1'b1;
                    state_d = RESP;
                end else if (cnt_inc == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus strobes and status decoded from registered state only
    always_comb begin
        busy      = (state_q != IDLE);
        mem_valid = (state_q == ACCESS);
        drive_bus = (state_q == ACCESS) && we_q;
        mem_rw    = !drive_bus;
    end

    assign mem_data = drive_bus ? wdata_q : 8'hzz;
    assign mem_addr = addr_q;
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit: directed scenarios followed by
// randomized accesses checked against a transaction-level expectation model.
module tb_bus_interface_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic        inc;
    logic [15:0] addr_in;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        mem_rw;
    logic        mem_valid;
    logic        mem_ready;
    logic [7:0]  tb_drv;

    int checks   = 0;
    int failures = 0;

    // Expected architectural state
    logic [15:0] m_addr;
    logic [7:0]  m_rdata;

    // Memory side drives the bus whenever the unit is not writing
    assign mem_data = mem_rw ? tb_drv : 8'hzz;

    bus_interface_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .inc       (inc),
        .addr_in   (addr_in),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_rw    (mem_rw),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access. waits = number of ready-low ACCESS cycles before ready;
    // waits >= TO means ready never arrives and the access times out.
    task automatic access(input bit w, input bit incr, input logic [15:0] a,
                          input logic [7:0] wd, input logic [7:0] rb,
                          input int waits, input bit pulse_req);
        int  n_acc;
        bit  tmo;
        logic [15:0] exp_a;
        exp_a = incr ? m_addr + 16'd1 : a;
        tmo   = (waits >= TO);
        n_acc = tmo ? TO : waits + 1;
        @(negedge clk);
        req = 1'b1; we = w; inc = incr; addr_in = a; wdata = wd;
        mem_ready = 1'b0; tb_drv = ~rb;
        @(posedge clk); #1;
        req = pulse_req;
        for (int c = 0; c < n_acc; c++) begin
            chk("acc_busy",  busy, 1);
            chk("acc_valid", mem_valid, 1);
            chk("acc_addr",  mem_addr, exp_a);
            chk("acc_rw",    mem_rw, !w);
            chk("acc_done",  done, 0);
            chk("acc_err",   err, 0);
            chk("acc_rdata", rdata, m_rdata);
            if (w) chk("acc_wdata", mem_data, wd);
            mem_ready = (c == waits);
            tb_drv    = (c == waits) ? rb : ~rb;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        m_addr = exp_a;
        if (!tmo && !w) m_rdata = rb;
        chk("resp_done",  done, !tmo);
        chk("resp_err",   err, tmo);
        chk("resp_busy",  busy, 1);
        chk("resp_valid", mem_valid, 0);
        chk("resp_rw",    mem_rw, 1);
        chk("resp_rdata", rdata, m_rdata);
        chk("resp_addr",  mem_addr, m_addr);
        chk("resp_bus",   mem_data, tb_drv);
        req = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy",  busy, 0);
        chk("idle_done",  done, 0);
        chk("idle_err",   err, 0);
        chk("idle_addr",  mem_addr, m_addr);
        chk("idle_rdata", rdata, m_rdata);
        if (pulse_req) begin
            @(posedge clk); #1;
            chk("ignore_busy", busy, 0);
            chk("ignore_done", done, 0);
        end
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; inc = 1'b0;
        addr_in = '0; wdata = '0; mem_ready = 1'b0; tb_drv = 8'h3C;
        m_addr = '0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_addr",  mem_addr, 16'h0000);
        chk("rst_rw",    mem_rw, 1);
        chk("rst_valid", mem_valid, 0);
        chk("rst_bus",   mem_data, tb_drv);
        @(negedge clk); reset = 1'b1;

        // Zero-wait read, 3-wait write, timeout read
        access(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 1'b0);
        access(1'b1, 1'b0, 16'h0200, 8'h5C, 8'h11, 3, 1'b0);
        access(1'b0, 1'b0, 16'h4000, 8'h00, 8'h99, TO, 1'b0);
        // Increment continues from the failed address
        access(1'b0, 1'b1, 16'hDEAD, 8'h00, 8'h42, 0, 1'b0);
        chk("inc_after_err", mem_addr, 16'h4001);
        // Increment wrap
        access(1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h01, 1, 1'b0);
        access(1'b0, 1'b1, 16'h1111, 8'h00, 8'h02, 0, 1'b0);
        chk("wrap_0000", mem_addr, 16'h0000);
        access(1'b0, 1'b1, 16'h2222, 8'h00, 8'h03, 2, 1'b0);
        chk("wrap_0001", mem_addr, 16'h0001);
        // Ready on the last allowed cycle completes rather than aborts
        access(1'b0, 1'b0, 16'h0BEE, 8'h00, 8'h7E, TO - 1, 1'b0);

        // Reset during the second wait cycle of a write
        @(negedge clk);
        req = 1'b1; we = 1'b1; inc = 1'b0; addr_in = 16'h0300; wdata = 8'h77;
        mem_ready = 1'b0; tb_drv = 8'h3C;
        @(posedge clk); #1;
        req = 1'b0;
        chk("mid_addr", mem_addr, 16'h0300);
        @(posedge clk); #1;
        chk("mid_wdata", mem_data, 8'h77);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        m_addr = '0; m_rdata = '0;
        chk("mrst_busy",  busy, 0);
        chk("mrst_done",  done, 0);
        chk("mrst_err",   err, 0);
        chk("mrst_rdata", rdata, 8'h00);
        chk("mrst_addr",  mem_addr, 16'h0000);
        chk("mrst_rw",    mem_rw, 1);
        chk("mrst_valid", mem_valid, 0);
        chk("mrst_bus",   mem_data, tb_drv);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_nodone", done, 0);
        access(1'b0, 1'b1, 16'h0000, 8'h00, 8'hC3, 1, 1'b0);
        chk("mrst_inc", mem_addr, 16'h0001);

        // req held during ACCESS and RESP is not queued
        access(1'b0, 1'b0, 16'h5555, 8'h00, 8'h6D, 2, 1'b1);

        // Randomized accesses
        for (int i = 0; i < 30; i++) begin
            bit          rw, ri, rp;
            logic [15:0] ra;
            logic [7:0]  rd, rb;
            int          rwt;
            rw  = 1'($urandom_range(0, 1));
            ri  = ($urandom_range(0, 3) == 0);
            rp  = ($urandom_range(0, 4) == 0);
            ra  = 16'($urandom);
            if (i == 5) ra = 16'hFFFF;
            rd  = 8'($urandom);
            rb  = 8'($urandom);
            rwt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                              : int'($urandom_range(0, 3));
            access(rw, ri, ra, rd, rb, rwt, rp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Sequencer between the CPU controller and the external 8-bit memory bus. It accepts one read or write request at a time, drives the 16-bit address and bus strobes, and holds the cycle open through memory wait states. On a read it captures the returned byte for the internal data-bus latches. It also aborts accesses that exceed a wait-state timeout.

## Interface
Parameters:
- TIMEOUT, 8, max ACCESS cycles without `mem_ready` before abort; legal range 1..255

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with `req`
- inc  in  1  1 = use last address + 1 instead of `addr_in`; sampled with `req`
- addr_in  in  16  access address
- wdata  in  8  write byte; sampled with `req`
- busy  out  1  high in ACCESS and RESP
- done  out  1  one-cycle pulse: access completed
- err  out  1  one-cycle pulse: access aborted on timeout
- rdata  out  8  last successfully read byte, feeds internal bus latch input
- mem_addr  out  16  external address
- mem_data  inout  8  external data bus; driven only during write ACCESS, else high-Z
- mem_rw  out  1  1 = read, 0 = write
- mem_valid  out  1  address/strobe valid
- mem_ready  in  1  memory ready; completes the access when high during ACCESS

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - With `req`=1, latch `we` and `wdata`.
  - Latch the address: `addr_in` if `inc`=0, otherwise previous `mem_addr` + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
  - Clear the wait counter and go to ACCESS.
  - `req`=0: stay in IDLE.
- ACCESS:
  - `mem_valid`=1, `mem_addr` = latched address, `mem_rw` = ~we.
  - If we=1, `mem_data` = latched `wdata`.
  - Each cycle, sample `mem_ready`:
    - 1: for a read, load `rdata` from `mem_data`; go to RESP with done flag set.
    - 0: increment the counter. If the counter reaches TIMEOUT, go to RESP with err flag set. Otherwise stay in ACCESS.
- RESP:
  - `done` or `err` high for exactly this cycle.
  - `mem_valid`=0, `mem_rw`=1, `mem_data` released.
  - Next state is always IDLE.
- `req` is ignored in ACCESS and RESP; it is not queued.
- Write and error accesses never change `rdata`.
- An error access does update `mem_addr`, so `inc` after an error continues from the failed address.
- `mem_addr` holds its value outside ACCESS.
- `done` and `err` are mutually exclusive. If `mem_ready`=1 on the cycle the counter would reach TIMEOUT, the result is `done`.

## Timing
- Reset (reset=0 at an edge), from any state, including mid-ACCESS:
  - state → IDLE; `busy`=0, `done`=0, `err`=0.
  - `rdata`=0x00, `mem_addr`=0x0000, `mem_rw`=1, `mem_valid`=0, `mem_data`=Z.
  - Counter cleared; no `done`/`err` pulse for the aborted access.
- All outputs are registered or decoded from state; there is no combinational path from `mem_ready` or `req` to any output.
- `req` accepted at edge N:
  - ACCESS occupies cycle N+1 and onward.
  - Zero-wait access: `mem_ready`=1 sampled at edge N+2; RESP (`done`=1) in cycle N+2; IDLE at N+3.
  - With k wait cycles: `done` appears in cycle N+2+k.
  - Timeout: `err` appears in cycle N+1+TIMEOUT.
- Minimum spacing between accepted requests: 3 cycles.
- `rdata` updates at the same edge that enters RESP and is stable while `done`=1.

## Test plan
- Zero-wait read: req, we=0, addr_in=0x1234, memory returns 0xA5 with ready=1. Expect `mem_valid`=1 and `mem_addr`=0x1234 in cycle N+1, `done` in N+2, `rdata`=0xA5, `busy` low at N+3.
- Write, 3 waits: wdata=0x5C, addr_in=0x0200, ready low for 3 ACCESS cycles. Expect `mem_rw`=0 and `mem_data`=0x5C for 4 cycles, `done` in N+5, `rdata` unchanged, then `mem_data`=Z.
- Timeout, TIMEOUT=8, ready held 0: expect `err` in cycle N+9, no `done`, `rdata` unchanged, `mem_addr` retains the address.
- Increment wrap: read at 0xFFFF, then req with inc=1. Expect second `mem_addr`=0x0000. A third inc read gives 0x0001.
- Reset mid-access: assert reset=0 during the 2nd wait cycle of a write. Expect all reset values at the next edge, `mem_data`=Z, no `done`. A fresh read afterward completes normally.
- Busy ignore: pulse req during ACCESS and RESP. Expect no extra access; exactly one `done` per accepted request.
